// File: rtl/seg7_led_port.sv
// Bus-slave LED / 4-digit 7-segment display port with autonomous digit multiplexing.
// Optional anti-ghosting blanking at each digit switch is enabled by defining SEG7_BLANK_EN.
module seg7_led_port #(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  lane_i,
  input  logic        wr_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  led_o,
  output logic [3:0]  dig_o,
  output logic [7:0]  seg_o
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(SCAN_DIV - 1);
  // Length of the all-off window at the start of each slot; zero when blanking is not built in.
  localparam int BlankLen =
`ifdef SEG7_BLANK_EN
    BLANK_CYCLES;
`else
    0 * BLANK_CYCLES;
`endif

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t      state_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [19:0] data_q, data_d;
  logic [3:0]  led_q, led_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] raw_q, raw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  dig_q, dig_d;
  logic [7:0]  seg_q, seg_d;

  logic        accept;
  logic        doWrite;
  logic [31:0] readMux;
  logic [3:0]  nibble;
  logic [7:0]  rawByte;
  logic [3:0]  dpBits;
  logic        blank;

  function automatic logic [6:0] hexDecode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // A transaction is accepted only from IDLE, so a held valid writes exactly once.
  assign accept  = (state_q == S_IDLE) && valid_i && sel_i;
  assign doWrite = accept && wr_i;

  always_comb begin
    readMux = 32'h0;
    case (addr_i)
      2'd0: readMux = {12'h0, data_q};
      2'd1: readMux = {28'h0, led_q};
      2'd2: readMux = {30'h0, ctrl_q};
      default: readMux = raw_q;
    endcase
  end

  always_comb begin
    data_d = data_q;
    led_d  = led_q;
    ctrl_d = ctrl_q;
    raw_d  = raw_q;
    if (doWrite) begin
      case (addr_i)
        2'd0: begin
          if (lane_i[0]) data_d[7:0]   = wdata_i[7:0];
          if (lane_i[1]) data_d[15:8]  = wdata_i[15:8];
          if (lane_i[2]) data_d[19:16] = wdata_i[19:16];
        end
        2'd1: if (lane_i[0]) led_d = wdata_i[3:0];
        2'd2: if (lane_i[0]) ctrl_d = wdata_i[1:0];
        default: begin
          for (int b = 0; b < 4; b++)
            if (lane_i[b]) raw_d[8*b +: 8] = wdata_i[8*b +: 8];
        end
      endcase
    end
  end

  // Scan state follows the post-write enable, so a disabling write beats a terminal-count advance.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!ctrl_d[0]) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == LastCnt) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    dpBits = data_d[19:16];
    case (idx_d)
      2'd0: begin nibble = data_d[3:0];   rawByte = raw_d[7:0];   end
      2'd1: begin nibble = data_d[7:4];   rawByte = raw_d[15:8];  end
      2'd2: begin nibble = data_d[11:8];  rawByte = raw_d[23:16]; end
      default: begin nibble = data_d[15:12]; rawByte = raw_d[31:24]; end
    endcase
    blank = !ctrl_d[0] || (int'(cnt_d) < BlankLen);
    if (blank) begin
      dig_d = 4'hF;
      seg_d = 8'hFF;
    end else begin
      dig_d = ~(4'b0001 << idx_d);
      seg_d = ctrl_d[1] ? ~rawByte : ~{dpBits[idx_d], hexDecode(nibble)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      led_q  <= '0;
      ctrl_q <= 2'b01;
      raw_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      dig_q  <= 4'hF;
      seg_q  <= 8'hFF;
    end else begin
      data_q <= data_d;
      led_q  <= led_d;
      ctrl_q <= ctrl_d;
      raw_q  <= raw_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      dig_q  <= dig_d;
      seg_q  <= seg_d;
    end
  end

  // Handshake: ready rises the cycle after acceptance and falls once valid is seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b1;
            rdata_q <= wr_i ? 32'h0 : readMux;
            state_q <= S_ACK;
          end
        end
        default: begin
          if (!valid_i) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;
  assign led_o   = ~led_q;
  assign dig_o   = dig_q;
  assign seg_o   = seg_q;

endmodule
